uart_rx16: RTL and testbench

UART_RX16 -- requirements
Module: uart_rx16

---
 rtl/uart_rx16.sv | 158 +++++++++++++++
 tb/tb_uart_rx16.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx16.sv
// 8N1 UART receiver clocked by a 16x-baud enable; samples the middle of each bit
// and reports a good byte (en_out) or a low stop bit (frame_err) with one-clk pulses.
`timescale 1ns/1ps
module uart_rx16 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en16,
    input  logic       ser_in,
    output logic [7:0] dout,
    output logic       en_out,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;
    state_t                 state_r, state_nxt_s;
    logic [3:0]             scnt_r, scnt_nxt_s;
    logic [2:0]             bidx_r, bidx_nxt_s;
    logic [7:0]             shreg_r, shreg_nxt_s;
    logic [7:0]             dout_nxt_s;
    logic                   en_out_nxt_s;
    logic                   ferr_nxt_s;

    assign rxs_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ser_in};
        end
    end

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        state_nxt_s  = state_r;
        scnt_nxt_s   = scnt_r;
        bidx_nxt_s   = bidx_r;
        shreg_nxt_s  = shreg_r;
        dout_nxt_s   = dout;
        en_out_nxt_s = 1'b0;
        ferr_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rxs_s) begin
                    state_nxt_s = START;
                    scnt_nxt_s  = 4'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (en16) begin
                    if (scnt_r == 4'd7) begin
                        scnt_nxt_s = 4'd0;
                        if (!rxs_s) begin
                            state_nxt_s = DATA;
                            bidx_nxt_s  = 3'd0;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        scnt_nxt_s = scnt_r + 4'd1;
                    end
                end else begin
                    scnt_nxt_s = scnt_r;
                end
            end
            DATA: begin
                if (en16) begin
                    // scnt wraps 15->0, so the next bit period starts clean
                    scnt_nxt_s = scnt_r + 4'd1;
                    if (scnt_r == 4'd15) begin
                        shreg_nxt_s = {rxs_s, shreg_r[7:1]};
                        bidx_nxt_s  = bidx_r + 3'd1;
                        if (bidx_r == 3'd7) begin
                            state_nxt_s = STOP;
                            scnt_nxt_s  = 4'd0;
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        shreg_nxt_s = shreg_r;
                    end
                end else begin
                    scnt_nxt_s = scnt_r;
                end
            end
            STOP: begin
                if (en16) begin
                    if (scnt_r == 4'd15) begin
                        scnt_nxt_s = 4'd0;
                        if (rxs_s) begin
                            dout_nxt_s   = shreg_r;
                            en_out_nxt_s = 1'b1;
                            state_nxt_s  = IDLE;
                        end else begin
                            ferr_nxt_s  = 1'b1;
                            state_nxt_s = BRK;
                        end
                    end else begin
                        scnt_nxt_s = scnt_r + 4'd1;
                    end
                end else begin
                    scnt_nxt_s = scnt_r;
                end
            end
            BRK: begin
                // A held-low line parks here until it returns high.
                if (en16 && rxs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BRK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                scnt_nxt_s  = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            scnt_r    <= 4'd0;
            bidx_r    <= 3'd0;
            shreg_r   <= 8'h00;
            dout      <= 8'h00;
            en_out    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            scnt_r    <= scnt_nxt_s;
            bidx_r    <= bidx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            dout      <= dout_nxt_s;
            en_out    <= en_out_nxt_s;
            frame_err <= ferr_nxt_s;
            busy      <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx16.sv
// Scoreboard bench for uart_rx16: directed frames push expected pulses,
// a negedge monitor pops and compares every en_out / frame_err pulse.
`timescale 1ns/1ps
module tb_uart_rx16;

    logic       clk = 1'b0;
    logic       reset;
    logic       en16;
    logic       ser_in;
    logic [7:0] dout;
    logic       en_out;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned ts_q[$];
    int unsigned en_total = 0;
    int          en_period = 326;
    bit          en_stop = 1'b0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    uart_rx16 #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .en16(en16), .ser_in(ser_in),
        .dout(dout), .en_out(en_out), .frame_err(frame_err), .busy(busy)
    );

    always #10 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // en16 pulse generator, one clk wide every en_period clks
    initial begin
        int cnt;
        cnt  = 0;
        en16 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt >= en_period - 1) begin
                cnt  = 0;
                en16 = !en_stop;
            end else begin
                cnt++;
                en16 = 1'b0;
            end
            if (en16) en_total++;
        end
    end

    // monitor: every output pulse must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (en_out || frame_err) begin
                if (en_out) ts_q.push_back(en_total);
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_pulse: en_out=%b frame_err=%b dout=%h, required no pulse",
                             en_out, frame_err, dout);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'({en_out, frame_err}), e.is_err ? 32'd1 : 32'd2);
                    if (!e.is_err) check("dout_at_en_out", 32'(dout), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation exceeded 95000 clk");
        $fatal(1);
    end

    task automatic wait_en(int n);
        repeat (n) begin
            int guard;
            guard = 0;
            @(posedge clk);
            while (!en16) begin
                guard++;
                if (guard > 2000) begin
                    $display("FAIL en16_timeout: no en16 within 2000 clk, required one");
                    $fatal(1);
                end
                @(posedge clk);
            end
            #2;
        end
    endtask

    task automatic send_bit(bit b);
        ser_in = b;
        wait_en(16);
    endtask

    task automatic send_frame(logic [7:0] d, bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic push_byte(logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        reset  = 1'b1;
        ser_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_en_out", 32'(en_out), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_en(2);

        // 'A' at the nominal 326-clk en16 rate
        push_byte(8'h41);
        send_frame(8'h41, 1'b1);
        en_period = 4;
        wait_en(4);
        @(negedge clk);
        check("a_busy_after", 32'(busy), 32'd0);
        check("a_pending", 32'(exp_q.size()), 32'd0);
        check("a_dout_hold", 32'(dout), 32'h41);

        // back-to-back frames, no idle gap
        send_bit(1'b1);
        push_byte(8'h55);
        push_byte(8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        send_bit(1'b1);
        check("b2b_pending", 32'(exp_q.size()), 32'd0);
        check("b2b_pulses", 32'(ts_q.size()), 32'd3);
        if (ts_q.size() >= 2)
            check("b2b_spacing", ts_q[ts_q.size()-1] - ts_q[ts_q.size()-2], 32'd160);

        // 5-en16 glitch on an idle line
        ser_in = 1'b0;
        wait_en(5);
        ser_in = 1'b1;
        wait_en(20);
        @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_dout", 32'(dout), 32'hAA);

        // stop bit low, then a 3-bit-time break
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
        send_frame(8'h33, 1'b0);
        wait_en(48);
        @(negedge clk);
        check("brk_busy", 32'(busy), 32'd1);
        check("brk_dout", 32'(dout), 32'hAA);
        send_bit(1'b1);
        send_bit(1'b1);
        check("brk_exit_busy", 32'(busy), 32'd0);
        check("ferr_pending", 32'(exp_q.size()), 32'd0);
        push_byte(8'h34);
        send_frame(8'h34, 1'b1);
        send_bit(1'b1);
        check("after_brk_dout", 32'(dout), 32'h34);

        // reset in the middle of the data bits of 0x7E, frame abandoned
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ser_in = 1'b1;
        wait_en(8);
        @(negedge clk);
        check("mid_frame_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_dout", 32'(dout), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_en_out", 32'(en_out), 32'd0);
        wait_en(16 * 7);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        push_byte(8'h31);
        send_frame(8'h31, 1'b1);
        send_bit(1'b1);
        check("after_rst_dout", 32'(dout), 32'h31);

        // en16 frozen with the line low: parked in START
        en_stop = 1'b1;
        repeat (8) @(posedge clk);
        #2 ser_in = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("freeze_busy", 32'(busy), 32'd1);
        check("freeze_dout", 32'(dout), 32'h31);
        en_stop = 1'b0;
        push_byte(8'h5A);
        send_frame(8'h5A, 1'b1);
        send_bit(1'b1);
        check("after_freeze_dout", 32'(dout), 32'h5A);
        check("final_busy", 32'(busy), 32'd0);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
